// File: rtl/mem_stage_sbuf_if.sv
// mem_stage_sbuf_if: backend data-memory bus between the MEM stage (master) and the memory (slave)
interface mem_stage_sbuf_if #(parameter int DW = 16, parameter int AW = 16);
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic          mem_dump;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;
    modport master(output mem_addr, mem_wdata, mem_rd, mem_wr, mem_dump, input mem_rdata, mem_done);
    modport slave(input mem_addr, mem_wdata, mem_rd, mem_wr, mem_dump, output mem_rdata, mem_done);
endinterface

// File: rtl/mem_stage_sbuf.sv
// mem_stage_sbuf: MEM stage with a FIFO store buffer that drains in the background and forwards to loads
module mem_stage_sbuf #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int RW    = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            alu_out_exmem,
    input  logic [DW-1:0]            st_data_exmem,
    input  logic                     mem_read_exmem,
    input  logic                     mem_write_exmem,
    input  logic                     reg_write_exmem,
    input  logic                     mem_to_reg_exmem,
    input  logic [RW-1:0]            wr_reg_exmem,
    input  logic                     flush_exmem,
    input  logic                     halt_exmem,
    input  logic                     dump_exmem,
    input  logic                     stall_in,
    output logic [DW-1:0]            alu_out_memwb,
    output logic [DW-1:0]            rd_data_memwb,
    output logic                     reg_write_memwb,
    output logic                     mem_to_reg_memwb,
    output logic [RW-1:0]            wr_reg_memwb,
    output logic                     stall_out,
    output logic [$clog2(DEPTH):0]   sb_count,
    mem_stage_sbuf_if.master         mem
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, DRAIN = 2'd1, LOAD = 2'd2, LDONE = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] sb_addr [DEPTH];
    logic [DW-1:0] sb_data [DEPTH];
    logic [PW-1:0] head, tail, idx;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] hold, fwd;
    logic          hit, op_ld, op_st, full, ld_miss, dump_ready, push, pop;

    assign op_ld      = mem_read_exmem & ~flush_exmem;
    assign op_st      = mem_write_exmem & ~flush_exmem & ~halt_exmem;
    assign full       = sb_count == (PW+1)'(DEPTH);
    assign ld_miss    = op_ld & ~hit & state != LDONE;
    assign dump_ready = sb_count == '0 && state == IDLE;
    assign stall_out  = ~rst & ((op_st & full) | ld_miss | (dump_exmem & ~dump_ready));
    assign push       = op_st & ~stall_in & ~stall_out;
    assign pop        = state == DRAIN && mem.mem_done;

    assign mem.mem_rd    = state == LOAD;
    assign mem.mem_wr    = state == DRAIN;
    assign mem.mem_addr  = state == LOAD ? ld_addr : state == DRAIN ? sb_addr[head] : '0;
    assign mem.mem_wdata = state == DRAIN ? sb_data[head] : '0;
    assign mem.mem_dump  = ~rst & dump_exmem & dump_ready & ~stall_in;

    // Walk oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((PW+1)'(i) < sb_count && sb_addr[idx] == alu_out_exmem[AW-1:0]) begin
                hit = 1'b1;
                fwd = sb_data[idx];
            end
        end
    end

    always_ff @(posedge clk)
        if (push) begin
            sb_addr[tail] <= alu_out_exmem[AW-1:0];
            sb_data[tail] <= st_data_exmem;
        end

    // A load miss outranks draining: a miss means no buffered store aliases it.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            sb_count <= '0;
            ld_addr  <= '0;
            hold     <= '0;
        end else begin
            head     <= head + PW'(pop);
            tail     <= tail + PW'(push);
            sb_count <= sb_count + (PW+1)'(push) - (PW+1)'(pop);
            state    <= state == IDLE  ? (ld_miss ? LOAD : sb_count != '0 ? DRAIN : IDLE)
                      : state == DRAIN ? (mem.mem_done ? IDLE : DRAIN)
                      : state == LOAD  ? (mem.mem_done ? LDONE : LOAD)
                      : (stall_in ? LDONE : IDLE);
            if (state == IDLE && ld_miss) ld_addr <= alu_out_exmem[AW-1:0];
            if (state == LOAD && mem.mem_done) hold <= mem.mem_rdata;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            alu_out_memwb    <= '0;
            rd_data_memwb    <= '0;
            reg_write_memwb  <= 1'b0;
            mem_to_reg_memwb <= 1'b0;
            wr_reg_memwb     <= '0;
        end else if (!stall_in) begin
            alu_out_memwb    <= alu_out_exmem;
            rd_data_memwb    <= state == LDONE ? hold : fwd;
            reg_write_memwb  <= reg_write_exmem & ~stall_out;
            mem_to_reg_memwb <= mem_to_reg_exmem & ~stall_out;
            wr_reg_memwb     <= wr_reg_exmem;
        end
endmodule
